// File: rtl/ws2812_note_display.sv
// WS2812 serialiser for the 24-LED note strip: curr_note drives LEDs 0..11, next_note LEDs 12..23.
// Optional AUTO_REFRESH_EN: self-start a frame whenever the live note rows differ from the shadow.
module ws2812_note_display #(
    parameter int unsigned T0H     = 20,
    parameter int unsigned T0L     = 42,
    parameter int unsigned T1H     = 40,
    parameter int unsigned T1L     = 22,
    parameter int unsigned TRST    = 3000,
    parameter logic [23:0] ON_GRB  = 24'h00_40_00,
    parameter logic [23:0] OFF_GRB = 24'h00_00_00
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] curr_note,
    input  logic [11:0] next_note,
    output logic        busy,
    output logic        done,
    output logic        dout
);

    localparam logic [11:0] T0hM1   = 12'(T0H - 1);
    localparam logic [11:0] T0lM1   = 12'(T0L - 1);
    localparam logic [11:0] T1hM1   = 12'(T1H - 1);
    localparam logic [11:0] T1lM1   = 12'(T1L - 1);
    localparam logic [11:0] TrstM1  = 12'(TRST - 1);
    localparam logic [4:0]  LastIdx = 5'd23;

    typedef enum logic [1:0] {StIdle, StSendHi, StSendLo, StLatch} state_e;

    state_e      state_q, state_d;
    logic [11:0] phase_q, phase_d;
    logic [4:0]  bit_q, bit_d;
    logic [4:0]  led_q, led_d;
    logic [23:0] shadow_q, shadow_d;
    logic        dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [23:0] colour;
    logic        cur_bit;
    logic [11:0] hi_last;
    logic [11:0] lo_last;
    logic        go;

    assign colour  = shadow_q[led_q] ? ON_GRB : OFF_GRB;
    assign cur_bit = colour[LastIdx - bit_q];
    assign hi_last = cur_bit ? T1hM1 : T0hM1;
    assign lo_last = cur_bit ? T1lM1 : T0lM1;

`ifdef AUTO_REFRESH_EN
    assign go = start | ({next_note, curr_note} != shadow_q);
`else
    assign go = start;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        led_d    = led_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A request coinciding with the done pulse is dropped.
                if (go && !done_q) begin
                    state_d  = StSendHi;
                    phase_d  = '0;
                    bit_d    = '0;
                    led_d    = '0;
                    shadow_d = {next_note, curr_note};
                    dout_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StSendHi: begin
                if (phase_q == hi_last) begin
                    state_d = StSendLo;
                    phase_d = '0;
                    dout_d  = 1'b0;
                end else begin
                    phase_d = phase_q + 12'd1;
                end
            end
            StSendLo: begin
                if (phase_q == lo_last) begin
                    phase_d = '0;
                    if (bit_q == LastIdx) begin
                        bit_d = '0;
                        if (led_q == LastIdx) begin
                            state_d = StLatch;
                            dout_d  = 1'b0;
                        end else begin
                            led_d   = led_q + 5'd1;
                            state_d = StSendHi;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        state_d = StSendHi;
                        dout_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 12'd1;
                end
            end
            StLatch: begin
                if (phase_q == TrstM1) begin
                    state_d = StIdle;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + 12'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            led_q    <= '0;
            shadow_q <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            led_q    <= led_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
